// File: rtl/rf_scoreboard_if.sv
// rtl/rf_scoreboard_if.sv - port bundle for the register file / busy scoreboard
// Purpose: groups the decode read ports, writeback, issue and flush signals of
//   rf_scoreboard so the datapath can be connected as one bus.
// Signals:
//   raddr_i      NRD*AW    read addresses, port k at [k*AW +: AW]
//   rdata_o      NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
//   rbusy_o      NRD       pending-producer flag per read port
//   wen_i/waddr_i/wdata_i  writeback
//   alloc_i/alloc_addr_i   issue-time destination allocation
//   flush_i      clears every busy bit
//   busy_vec_o   NREGS     registered busy bits
// Modports: master drives the requests, slave is the register file.
interface rf_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   raddr_i;
  logic [NRD*XLEN-1:0] rdata_o;
  logic [NRD-1:0]      rbusy_o;
  logic                wen_i;
  logic [AW-1:0]       waddr_i;
  logic [XLEN-1:0]     wdata_i;
  logic                alloc_i;
  logic [AW-1:0]       alloc_addr_i;
  logic                flush_i;
  logic [NREGS-1:0]    busy_vec_o;

  modport master (
    output raddr_i, wen_i, waddr_i, wdata_i, alloc_i, alloc_addr_i, flush_i,
    input  rdata_o, rbusy_o, busy_vec_o
  );

  modport slave (
    input  raddr_i, wen_i, waddr_i, wdata_i, alloc_i, alloc_addr_i, flush_i,
    output rdata_o, rbusy_o, busy_vec_o
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - parametrised register file with per-register busy scoreboard
// Purpose: integer register file for the decode/writeback boundary. Register 0
//   is hardwired to zero, reads are combinational with same-cycle writeback
//   bypass, and each register carries a busy bit set at issue, cleared at
//   writeback and cleared wholesale by a flush.
// Ports:
//   clk_i     rising-edge clock
//   reset_ni  asynchronous active-low reset (clears registers and busy bits)
//   bus       rf_scoreboard_if slave: read ports, writeback, alloc, flush,
//             busy vector
module rf_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input logic          clk_i,
  input logic          reset_ni,
  rf_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             wen_eff;
  logic             wr_en;

  // Inputs are ignored while reset is held, which also keeps the read bypass
  // from leaking wdata_i onto rdata_o during reset.
  assign wen_eff = bus.wen_i & reset_ni;
  assign wr_en   = wen_eff && (bus.waddr_i != '0);

  // Register 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[bus.waddr_i] <= bus.wdata_i;
    end
  end

  // Priority per register: flush, then a new producer, then writeback.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (bus.flush_i) begin
        busy_d[r] = 1'b0;
      end else if (bus.alloc_i && (bus.alloc_addr_i == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (bus.wen_i && (bus.waddr_i == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.busy_vec_o = busy_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;

    assign ra  = bus.raddr_i[k*AW +: AW];
    // A same-cycle writeback to the read address forwards its data and
    // retires the producer as far as this reader is concerned.
    assign hit = wen_eff && (bus.waddr_i == ra);

    assign bus.rdata_o[k*XLEN +: XLEN] = (ra == '0) ? '0 :
                                         hit        ? bus.wdata_i :
                                                      regs_q[ra];
    assign bus.rbusy_o[k] = (ra != '0) && !hit && busy_q[ra];
  end
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb/tb_rf_scoreboard.sv - directed and randomized check of rf_scoreboard
module tb_rf_scoreboard;
  logic clk_i = 1'b0;
  logic reset_ni;

  always #5 clk_i = ~clk_i;

  rf_scoreboard_if #(.XLEN(32), .NREGS(32), .NRD(2)) b0 ();
  rf_scoreboard_if #(.XLEN(64), .NREGS(16), .NRD(3)) b1 ();

  rf_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2)) u_dut0 (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (b0)
  );

  rf_scoreboard #(.XLEN(64), .NREGS(16), .NRD(3)) u_dut1 (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (b1)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: architectural register contents and pending producers.
  logic [31:0] m_regs  [32];
  bit          m_busy  [32];
  logic [63:0] m1_regs [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd0(input int k);
    return 64'(b0.rdata_o[k*32 +: 32]);
  endfunction

  function automatic logic [63:0] rb0(input int k);
    return 64'(b0.rbusy_o[k]);
  endfunction

  function automatic logic [63:0] vec0();
    return 64'(b0.busy_vec_o);
  endfunction

  function automatic logic [63:0] rd1(input int k);
    return b1.rdata_o[k*64 +: 64];
  endfunction

  function automatic logic [63:0] val1(input int r);
    return {32'(r) * 32'h0101_0101, 32'hFACE_0000 + 32'(r)};
  endfunction

  // Expected read data: zero register, then the value being written back this
  // cycle, then the stored architectural value.
  function automatic logic [63:0] exp_rd0(input logic [4:0] a);
    if (!reset_ni || a == 5'd0) return 64'd0;
    if (b0.wen_i && b0.waddr_i == a) return 64'(b0.wdata_i);
    return 64'(m_regs[a]);
  endfunction

  function automatic logic [63:0] exp_bz0(input logic [4:0] a);
    if (!reset_ni || a == 5'd0) return 64'd0;
    if (b0.wen_i && b0.waddr_i == a) return 64'd0;
    return 64'(m_busy[a]);
  endfunction

  function automatic logic [63:0] exp_rd1(input logic [3:0] a);
    if (a == 4'd0) return 64'd0;
    if (b1.wen_i && b1.waddr_i == a) return b1.wdata_i;
    return m1_regs[a];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    for (int r = 0; r < 16; r++) m1_regs[r] = '0;
  endtask

  task automatic idle0();
    b0.wen_i = 1'b0; b0.waddr_i = 5'd0; b0.wdata_i = 32'd0;
    b0.alloc_i = 1'b0; b0.alloc_addr_i = 5'd0; b0.flush_i = 1'b0;
  endtask

  task automatic set_ra0(input logic [4:0] a0, input logic [4:0] a1);
    b0.raddr_i = {a1, a0};
  endtask

  task automatic set_ra1(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    b1.raddr_i = {a2, a1, a0};
  endtask

  // Apply this cycle's requests to the model, then advance one clock.
  task automatic tick();
    if (reset_ni) begin
      if (b0.wen_i && b0.waddr_i != 5'd0) m_regs[b0.waddr_i] = b0.wdata_i;
      if (b0.flush_i) begin
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      end else begin
        if (b0.wen_i) m_busy[b0.waddr_i] = 1'b0;
        if (b0.alloc_i && b0.alloc_addr_i != 5'd0) m_busy[b0.alloc_addr_i] = 1'b1;
      end
      if (b1.wen_i && b1.waddr_i != 4'd0) m1_regs[b1.waddr_i] = b1.wdata_i;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all0(input string tag);
    logic [4:0]  a;
    logic [31:0] v;
    for (int k = 0; k < 2; k++) begin
      a = b0.raddr_i[k*5 +: 5];
      chk($sformatf("%s_rdata%0d", tag, k), rd0(k), exp_rd0(a));
      chk($sformatf("%s_rbusy%0d", tag, k), rb0(k), exp_bz0(a));
    end
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    chk($sformatf("%s_busyvec", tag), vec0(), 64'(v));
  endtask

  initial begin
    reset_ni = 1'b0;
    idle0();
    b0.raddr_i = '0;
    b1.raddr_i = '0; b1.wen_i = 1'b0; b1.waddr_i = 4'd0; b1.wdata_i = 64'd0;
    b1.alloc_i = 1'b0; b1.alloc_addr_i = 4'd0; b1.flush_i = 1'b0;
    model_reset();

    // Reset state, including a writeback request that must be ignored.
    set_ra0(5'd1, 5'd31);
    b0.wen_i = 1'b1; b0.waddr_i = 5'd1; b0.wdata_i = 32'hFFFF_FFFF;
    #3;
    chk("rst_rdata0", rd0(0), 64'd0);
    chk("rst_rdata1", rd0(1), 64'd0);
    chk("rst_rbusy0", rb0(0), 64'd0);
    chk("rst_busyvec", vec0(), 64'd0);
    b0.wen_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    tick();
    #1;
    chk("post_rst_rd1", rd0(0), 64'd0);
    chk("post_rst_rd31", rd0(1), 64'd0);
    check_all0("post_rst");

    // Write then read, and writes to register 0 discarded.
    b0.wen_i = 1'b1; b0.waddr_i = 5'd5; b0.wdata_i = 32'hDEAD_BEEF;
    tick();
    b0.wen_i = 1'b0; set_ra0(5'd5, 5'd0);
    #1;
    chk("wr_rd5", rd0(0), 64'hDEAD_BEEF);
    check_all0("wr5");
    b0.wen_i = 1'b1; b0.waddr_i = 5'd0; b0.wdata_i = 32'h1234_5678;
    #1;
    chk("x0_bypass", rd0(1), 64'd0);
    tick();
    b0.wen_i = 1'b0;
    #1;
    chk("x0_after", rd0(1), 64'd0);

    // Same-cycle bypass.
    b0.wen_i = 1'b1; b0.waddr_i = 5'd7; b0.wdata_i = 32'hA5A5_A5A5; set_ra0(5'd7, 5'd5);
    #1;
    chk("byp_same", rd0(0), 64'hA5A5_A5A5);
    chk("byp_other", rd0(1), 64'hDEAD_BEEF);
    check_all0("byp");
    tick();
    b0.wen_i = 1'b0;
    #1;
    chk("byp_next", rd0(0), 64'hA5A5_A5A5);

    // Scoreboard set by alloc, cleared by writeback.
    b0.alloc_i = 1'b1; b0.alloc_addr_i = 5'd9; set_ra0(5'd9, 5'd9);
    #1;
    chk("alloc_same_rbusy", rb0(0), 64'd0);
    tick();
    b0.alloc_i = 1'b0;
    #1;
    chk("alloc_rbusy0", rb0(0), 64'd1);
    chk("alloc_rbusy1", rb0(1), 64'd1);
    chk("alloc_vec9", 64'(b0.busy_vec_o[9]), 64'd1);
    b0.wen_i = 1'b1; b0.waddr_i = 5'd9; b0.wdata_i = 32'h55;
    #1;
    chk("wb_rbusy", rb0(0), 64'd0);
    chk("wb_rdata", rd0(0), 64'h55);
    chk("wb_vec9_held", 64'(b0.busy_vec_o[9]), 64'd1);
    tick();
    b0.wen_i = 1'b0;
    #1;
    chk("wb_vec9_clr", 64'(b0.busy_vec_o[9]), 64'd0);
    check_all0("wb");

    // Alloc beats writeback; flush beats alloc; register 0 never busy.
    b0.alloc_i = 1'b1; b0.alloc_addr_i = 5'd3;
    tick();
    b0.wen_i = 1'b1; b0.waddr_i = 5'd3; b0.wdata_i = 32'h33;
    tick();
    b0.wen_i = 1'b0; b0.alloc_addr_i = 5'd4;
    #1;
    chk("alloc_beats_wb", 64'(b0.busy_vec_o[3]), 64'd1);
    tick();
    b0.alloc_i = 1'b0;
    #1;
    chk("busy_3_4", vec0(), 64'h18);
    b0.flush_i = 1'b1; b0.alloc_i = 1'b1; b0.alloc_addr_i = 5'd6;
    b0.wen_i = 1'b1; b0.waddr_i = 5'd5; b0.wdata_i = 32'h11; set_ra0(5'd3, 5'd4);
    #1;
    chk("flush_same_rbusy0", rb0(0), 64'd1);
    chk("flush_same_rbusy1", rb0(1), 64'd1);
    tick();
    idle0();
    #1;
    chk("flush_vec", vec0(), 64'd0);
    check_all0("flush");
    b0.alloc_i = 1'b1; b0.alloc_addr_i = 5'd0; set_ra0(5'd0, 5'd0);
    tick();
    b0.alloc_i = 1'b0;
    #1;
    chk("alloc0_vec", vec0(), 64'd0);
    chk("alloc0_rbusy", rb0(0), 64'd0);

    // Reset in the middle of a cycle drops the pending write and alloc.
    b0.wen_i = 1'b1; b0.waddr_i = 5'd1; b0.wdata_i = 32'h1111_0001;
    tick();
    b0.waddr_i = 5'd31; b0.wdata_i = 32'h3131_3131; b0.alloc_i = 1'b1; b0.alloc_addr_i = 5'd31;
    tick();
    idle0(); set_ra0(5'd1, 5'd31);
    #1;
    chk("pre_rst_rd1", rd0(0), 64'h1111_0001);
    chk("pre_rst_rd31", rd0(1), 64'h3131_3131);
    chk("pre_rst_rbusy31", rb0(1), 64'd1);
    b0.wen_i = 1'b1; b0.waddr_i = 5'd1; b0.wdata_i = 32'h0000_0BAD;
    b0.alloc_i = 1'b1; b0.alloc_addr_i = 5'd2;
    #1;
    reset_ni = 1'b0;
    #1;
    chk("mid_rst_rd1", rd0(0), 64'd0);
    chk("mid_rst_rd31", rd0(1), 64'd0);
    chk("mid_rst_vec", vec0(), 64'd0);
    chk("mid_rst_rbusy", rb0(1), 64'd0);
    model_reset();
    idle0();
    @(negedge clk_i);
    reset_ni = 1'b1;
    tick();
    #1;
    chk("after_rst_rd1", rd0(0), 64'd0);
    check_all0("after_rst");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      b0.wen_i        = 1'($urandom_range(0, 1));
      b0.waddr_i      = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      b0.wdata_i      = $urandom;
      b0.alloc_i      = 1'($urandom_range(0, 1));
      b0.alloc_addr_i = 5'($urandom_range(0, 7));
      b0.flush_i      = ($urandom_range(0, 15) == 0);
      set_ra0(5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      #1;
      check_all0($sformatf("rnd%0d", i));
      tick();
    end
    idle0();

    // Wider configuration: three ports, 16 registers, 64-bit data.
    for (int r = 1; r < 16; r++) begin
      b1.wen_i = 1'b1; b1.waddr_i = 4'(r); b1.wdata_i = val1(r);
      tick();
    end
    b1.wen_i = 1'b0;
    set_ra1(4'd1, 4'd8, 4'd15);
    #1;
    chk("sweep_p0", rd1(0), val1(1));
    chk("sweep_p1", rd1(1), val1(8));
    chk("sweep_p2", rd1(2), val1(15));
    for (int a = 0; a < 16; a++) begin
      set_ra1(4'(a), 4'(a), 4'(a));
      #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("sweep_same%0d_p%0d", a, k), rd1(k), (a == 0) ? 64'd0 : val1(a));
      end
    end
    for (int i = 0; i < 60; i++) begin
      b1.wen_i   = 1'($urandom_range(0, 1));
      b1.waddr_i = 4'($urandom_range(0, 15));
      b1.wdata_i = {$urandom, $urandom};
      set_ra1(4'($urandom_range(0, 15)), b1.waddr_i, 4'($urandom_range(0, 15)));
      #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("sweep_rnd%0d_p%0d", i, k), rd1(k), exp_rd1(b1.raddr_i[k*4 +: 4]));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
